beat_sequencer: RTL and testbench
=================================

# beat_sequencer

Playback controller for the step sequencer. Latches the beat period from the tempo selector, generates the master `beat_pulse`, and advances the step index through a measure. It owns play/pause/stop control: it sits between the tempo selector and the measure/voice logic, and is the only block that decides when a beat happens.

## Interface
- `STEPS`, default 8: steps per measure, valid range 2..256.
- `TEMPO_W`, default 22: width of the tempo period input.
- `STEP_W`, default `$clog2(STEPS)`: width of `step`.

- `clk`  in  1  system clock
- `n_rst`  in  1  reset, asynchronous, active-low
- `tempo`  in  TEMPO_W  beat period minus one, in clk cycles
- `play_button`  in  1  single-cycle pulse: start / pause / resume
- `stop_button`  in  1  single-cycle pulse: stop and rewind
- `beat_pulse`  out  1  one-cycle strobe per beat
- `measure_pulse`  out  1  one-cycle strobe coincident with the `beat_pulse` of step 0
- `step`  out  STEP_W  current step index, 0..STEPS-1
- `playing`  out  1  high in PLAYING (and COUNT_IN when enabled)
- `count_in`  out  1  high during count-in beats; constant 0 without COUNT_IN_EN

## Operation
- Internal registers: state, `cnt` [TEMPO_W-1:0], `period_q` [TEMPO_W-1:0], `step`, beat count-in counter [1:0].
- Reset values: state=STOPPED; `cnt`, `period_q`, `step` = 0; all outputs = 0.
- STOPPED, `play_button`:
  - Go to PLAYING (or COUNT_IN).
  - Set `cnt`=0, `step`=0, `period_q`=`tempo`.
  - Emit the downbeat: `beat_pulse`=1 and `measure_pulse`=1 in the following cycle.
- PLAYING:
  - `cnt` increments each cycle.
  - When `cnt`==`period_q`: set `cnt`=0, emit `beat_pulse`, and advance `step` (STEPS-1 wraps to 0). Reload `period_q`=`tempo`.
  - `measure_pulse` is high together with `beat_pulse` whenever the new step is 0.
- PLAYING, `play_button`: go to PAUSED.
  - `cnt` and `step` are frozen; no pulses.
- PAUSED, `play_button`: go back to PLAYING.
  - Counting continues from the held `cnt`; no immediate beat.
- `stop_button` in any state: go to STOPPED.
  - `cnt`=0, `step`=0; no pulse that cycle.
- `stop_button` and `play_button` in the same cycle: stop wins.
- `tempo` is sampled only at start and at beat boundaries. Mid-beat tempo changes take effect from the next beat and never truncate the current beat.
- `tempo`=0 gives a beat every cycle (`beat_pulse` held high while playing).
- Counter width equals TEMPO_W. `cnt` never exceeds `period_q`, so no overflow is possible.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Button response: the button is sampled at edge k; the state change and first downbeat are visible in cycle k+1.
- Beat spacing: `period_q`+1 cycles between consecutive `beat_pulse` assertions while PLAYING.
- `step` updates in the same cycle that `beat_pulse` is high; the value shown is the step being started.
- Pause preserves phase: the total PLAYING cycles between beats equals `period_q`+1 regardless of the pause length.
- Reset assertion mid-beat forces all state to reset values asynchronously. After release the block idles in STOPPED.

## Configuration
- `BEAT_SEQUENCER_COUNT_IN_EN` defined:
  - STOPPED + `play_button` enters COUNT_IN.
  - COUNT_IN emits 4 beats at the normal spacing with `beat_pulse`=1, `count_in`=1, `step`=0 and `measure_pulse`=0. The first count-in beat is in cycle k+1.
  - The beat after the 4th count-in beat enters PLAYING as the step-0 downbeat with `measure_pulse`=1, in cycle k+1+4·(P+1).
  - `play_button` is ignored in COUNT_IN; `stop_button` returns to STOPPED.
- Undefined:
  - The COUNT_IN state and its counter are not built.
  - `count_in` is tied to 0 and play starts directly with the downbeat.

## Test plan
- Reset, then `tempo`=3, pulse `play_button` at edge k:
  - `beat_pulse`/`measure_pulse` high in cycle k+1 with `step`=0.
  - Next beats at k+5 and k+9 with `step`=1 and 2.
- `tempo`=1, STEPS=8, run 9 beats: `step` sequence 0..7,0; `measure_pulse` high only on the 1st and 9th beats.
- Pause behaviour with `tempo`=3:
  - Pause 2 cycles after a beat, hold 20 cycles, resume: next beat arrives exactly 2 PLAYING cycles after resume, `step` unchanged while paused.
  - A change of `tempo` from 3 to 7 mid-beat: the current beat spacing stays 4, later spacing is 8.
- Simultaneous `play_button`+`stop_button` while PLAYING at `step`=5:
  - State becomes STOPPED with `step`=0, `playing`=0 and no `beat_pulse`.
  - Drop `n_rst` mid-beat: all outputs read 0 immediately.
- With COUNT_IN_EN, `tempo`=3, play at edge k:
  - `count_in` beats at k+1, k+5, k+9, k+13.
  - Downbeat with `measure_pulse` and `step`=0 at k+17; stop during count-in returns to STOPPED.

Source files
------------

// File: rtl/beat_sequencer.sv
// beat_sequencer: playback controller for the step sequencer.
//
// The block latches the beat period from the tempo selector and generates
// the master beat strobe. It advances the step index through a measure and
// owns play / pause / stop. It is the only block that decides when a beat
// happens.
//
// Optional feature: define BEAT_SEQUENCER_COUNT_IN_EN to build a four-beat
// count-in. The count-in runs between STOPPED and the first downbeat. In the
// default build the COUNT_IN state and its counter do not exist.
//
// Parameters:
//   STEPS    steps per measure (2..256)
//   TEMPO_W  width of the tempo period input
//   STEP_W   width of the step index
// Ports:
//   clk            system clock
//   n_rst          asynchronous active-low reset
//   tempo          beat period minus one, in clk cycles
//   play_button    single-cycle pulse: start / pause / resume
//   stop_button    single-cycle pulse: stop and rewind (beats play)
//   beat_pulse     one-cycle strobe per beat
//   measure_pulse  strobe coincident with the beat that starts step 0
//   step           current step index
//   playing        high while PLAYING (and COUNT_IN)
//   count_in       high while counting in (constant 0 without the feature)
module beat_sequencer #(
  parameter int STEPS   = 8,
  parameter int TEMPO_W = 22,
  parameter int STEP_W  = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic               play_button,
  input  logic               stop_button,
  output logic               beat_pulse,
  output logic               measure_pulse,
  output logic [STEP_W-1:0]  step,
  output logic               playing,
  output logic               count_in
);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_PLAYING  = 2'd1,
    ST_PAUSED   = 2'd2
`ifdef BEAT_SEQUENCER_COUNT_IN_EN
    ,ST_COUNT_IN = 2'd3
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [TEMPO_W-1:0]   cnt_q, cnt_d;
  logic [TEMPO_W-1:0]   period_q, period_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic                 beat_q, beat_d;
  logic                 measure_q, measure_d;
`ifdef BEAT_SEQUENCER_COUNT_IN_EN
  logic [1:0]           cin_q, cin_d;
`endif

  logic                 beat_due;
  logic [STEP_W-1:0]    step_next;

  assign beat_due  = (cnt_q == period_q);
  assign step_next = (step_q == STEP_W'(STEPS - 1)) ? '0 : step_q + 1'b1;

  // State register. The beat and measure strobes are registered together
  // with the state, so no input reaches an output combinationally.
  // NOTE: sequential state uses non-blocking assignments only. This way every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_STOPPED;
      cnt_q     <= '0;
      period_q  <= '0;
      step_q    <= '0;
      beat_q    <= 1'b0;
      measure_q <= 1'b0;
`ifdef BEAT_SEQUENCER_COUNT_IN_EN
      cin_q     <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      step_q    <= step_d;
      beat_q    <= beat_d;
      measure_q <= measure_d;
`ifdef BEAT_SEQUENCER_COUNT_IN_EN
      cin_q     <= cin_d;
`endif
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default at the top of the block. Otherwise a
  // branch that skips an assignment would infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    step_d    = step_q;
    beat_d    = 1'b0;
    measure_d = 1'b0;
`ifdef BEAT_SEQUENCER_COUNT_IN_EN
    cin_d     = cin_q;
`endif

    case (state_q)
      ST_STOPPED: begin
        if (play_button) begin
          cnt_d    = '0;
          step_d   = '0;
          period_d = tempo;
          beat_d   = 1'b1;
`ifdef BEAT_SEQUENCER_COUNT_IN_EN
          state_d  = ST_COUNT_IN;
          cin_d    = 2'd0;
`else
          state_d   = ST_PLAYING;
          measure_d = 1'b1;
`endif
        end
      end

      ST_PLAYING: begin
        // The cycle in which pause is pressed is still a PLAYING cycle, so it
        // counts like any other. Together with a resume edge that does not
        // count, this keeps the beat phase intact across a pause of any
        // length.
        if (beat_due) begin
          cnt_d     = '0;
          period_d  = tempo;
          step_d    = step_next;
          beat_d    = 1'b1;
          measure_d = (step_next == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (play_button) state_d = ST_PAUSED;
      end

      ST_PAUSED: begin
        if (play_button) state_d = ST_PLAYING;
      end

`ifdef BEAT_SEQUENCER_COUNT_IN_EN
      ST_COUNT_IN: begin
        // play_button is ignored here. Four count-in beats run at step 0,
        // and the following beat becomes the real downbeat.
        if (beat_due) begin
          cnt_d    = '0;
          period_d = tempo;
          beat_d   = 1'b1;
          if (cin_q == 2'd3) begin
            state_d   = ST_PLAYING;
            measure_d = 1'b1;
          end else begin
            cin_d = cin_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      default: state_d = ST_STOPPED;
    endcase

    // Stop overrides everything, including a simultaneous play.
    if (stop_button) begin
      state_d   = ST_STOPPED;
      cnt_d     = '0;
      step_d    = '0;
      beat_d    = 1'b0;
      measure_d = 1'b0;
    end
  end

  // Outputs: decoded from registered state only.
  always_comb begin
    beat_pulse    = beat_q;
    measure_pulse = measure_q;
    step          = step_q;
`ifdef BEAT_SEQUENCER_COUNT_IN_EN
    playing       = (state_q == ST_PLAYING) || (state_q == ST_COUNT_IN);
    count_in      = (state_q == ST_COUNT_IN);
`else
    playing       = (state_q == ST_PLAYING);
    count_in      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer (STEPS=8, TEMPO_W=22).
//
// The bench applies a vector table first. Hand-written sequences then cover
// nine beats at tempo 1, pause/resume phase, a mid-beat tempo change,
// stop+play, and asynchronous reset. Under BEAT_SEQUENCER_COUNT_IN_EN the
// count-in sequence runs instead.
//
// Cycle convention: tick() drives the inputs and waits for a rising edge,
// then for 1 time unit. Outputs read after tick() show the effect of that edge.
module tb_beat_sequencer;

  localparam int STEPS   = 8;
  localparam int TEMPO_W = 22;
  localparam int STEP_W  = 3;

  logic               clk;
  logic               n_rst;
  logic [TEMPO_W-1:0] tempo;
  logic               play_button;
  logic               stop_button;
  logic               beat_pulse;
  logic               measure_pulse;
  logic [STEP_W-1:0]  step;
  logic               playing;
  logic               count_in;

  int total;
  int bad;

  beat_sequencer #(.STEPS(STEPS), .TEMPO_W(TEMPO_W)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .tempo         (tempo),
    .play_button   (play_button),
    .stop_button   (stop_button),
    .beat_pulse    (beat_pulse),
    .measure_pulse (measure_pulse),
    .step          (step),
    .playing       (playing),
    .count_in      (count_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        play;
    logic        stop;
    int          tmp;
    logic        e_beat;
    logic        e_meas;
    int          e_step;
    logic        e_playing;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic play, input logic stop);
    play_button = play;
    stop_button = stop;
    @(posedge clk);
    #1;
    play_button = 1'b0;
    stop_button = 1'b0;
  endtask

  // Advance until the next beat_pulse and return the number of edges taken.
  task automatic wait_beat(output int n);
    n = 0;
    do begin
      tick(1'b0, 1'b0);
      n++;
    end while (!beat_pulse && n < 64);
    if (!beat_pulse) check("beat_timeout", int'(beat_pulse), 1);
  endtask

  initial begin
    vec_t vecs[16];
    int   n;
    int   beats_seen;

    total = 0;
    bad   = 0;
    n_rst = 1'b0;
    tempo = '0;
    play_button = 1'b0;
    stop_button = 1'b0;

    #12;
    check("rst_beat",     int'(beat_pulse),    0);
    check("rst_measure",  int'(measure_pulse), 0);
    check("rst_step",     int'(step),          0);
    check("rst_playing",  int'(playing),       0);
    check("rst_count_in", int'(count_in),      0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

`ifndef BEAT_SEQUENCER_COUNT_IN_EN
    // ---------------- table: {play, stop, tempo, beat, meas, step, playing}
    vecs[0]  = '{1'b1, 1'b0, 3, 1'b1, 1'b1, 0, 1'b1}; // k+1 downbeat
    vecs[1]  = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 3, 1'b1, 1'b0, 1, 1'b1}; // k+5 step 1
    vecs[5]  = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 1, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 3, 1'b1, 1'b0, 2, 1'b1}; // k+9 step 2
    vecs[9]  = '{1'b0, 1'b1, 3, 1'b0, 1'b0, 0, 1'b0}; // stop
    vecs[10] = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 0, 1'b1}; // tempo 0
    vecs[12] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1, 1'b1}; // beat every cycle
    vecs[13] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 2, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0}; // stop wins
    vecs[15] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      tempo = TEMPO_W'(vecs[i].tmp);
      tick(vecs[i].play, vecs[i].stop);
      check($sformatf("vec%0d_beat", i),     int'(beat_pulse),    int'(vecs[i].e_beat));
      check($sformatf("vec%0d_measure", i),  int'(measure_pulse), int'(vecs[i].e_meas));
      check($sformatf("vec%0d_step", i),     int'(step),          vecs[i].e_step);
      check($sformatf("vec%0d_playing", i),  int'(playing),       int'(vecs[i].e_playing));
      check($sformatf("vec%0d_count_in", i), int'(count_in),      0);
    end

    // ---------------- tempo 1: nine beats, step 0..7,0
    tempo = 22'd1;
    tick(1'b1, 1'b0);
    check("t1_b0_beat",    int'(beat_pulse),    1);
    check("t1_b0_measure", int'(measure_pulse), 1);
    check("t1_b0_step",    int'(step),          0);
    for (int i = 1; i < 9; i++) begin
      wait_beat(n);
      check($sformatf("t1_b%0d_spacing", i), n, 2);
      check($sformatf("t1_b%0d_step", i), int'(step), i % STEPS);
      check($sformatf("t1_b%0d_measure", i), int'(measure_pulse), (i == 8) ? 1 : 0);
    end

    // ---------------- pause / resume preserves phase
    tick(1'b0, 1'b1);
    tempo = 22'd3;
    tick(1'b1, 1'b0);                    // beat, cycle b
    check("pz_start_beat", int'(beat_pulse), 1);
    tick(1'b0, 1'b0);                    // cycle b+1
    check("pz_b1_beat", int'(beat_pulse), 0);
    tick(1'b1, 1'b0);                    // paused from b+2
    check("pz_paused_playing", int'(playing), 0);
    check("pz_paused_beat",    int'(beat_pulse), 0);
    beats_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0);
      if (beat_pulse || step != 3'd0) beats_seen++;
    end
    check("pz_hold_quiet", beats_seen, 0);
    tick(1'b1, 1'b0);                    // resume, cycle r+1
    check("pz_r1_playing", int'(playing),    1);
    check("pz_r1_beat",    int'(beat_pulse), 0);
    tick(1'b0, 1'b0);                    // r+2
    check("pz_r2_beat",    int'(beat_pulse), 0);
    tick(1'b0, 1'b0);                    // r+3: second playing edge completes the beat
    check("pz_r3_beat",    int'(beat_pulse), 1);
    check("pz_r3_step",    int'(step),       1);

    // ---------------- mid-beat tempo change 3 -> 7
    tick(1'b0, 1'b0);
    tempo = 22'd7;
    wait_beat(n);
    check("tc_spacing_cur", n + 1, 4);
    check("tc_step2", int'(step), 2);
    wait_beat(n);
    check("tc_spacing_new", n, 8);
    check("tc_step3", int'(step), 3);
    tempo = 22'd3;
    wait_beat(n);
    check("tc_spacing_held", n, 8);
    wait_beat(n);
    check("tc_spacing_back", n, 4);
    check("tc_step5", int'(step), 5);

    // ---------------- play+stop together at step 5
    tick(1'b1, 1'b1);
    check("ps_step",    int'(step),          0);
    check("ps_playing", int'(playing),       0);
    check("ps_beat",    int'(beat_pulse),    0);
    check("ps_measure", int'(measure_pulse), 0);
    beats_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0);
      if (beat_pulse || playing) beats_seen++;
    end
    check("ps_stays_stopped", beats_seen, 0);

    // ---------------- asynchronous reset in the middle of a beat cycle
    tick(1'b1, 1'b0);
    wait_beat(n);
    check("ar_pre_step", int'(step), 1);
    #2 n_rst = 1'b0;
    #1;
    check("ar_beat",    int'(beat_pulse),    0);
    check("ar_measure", int'(measure_pulse), 0);
    check("ar_step",    int'(step),          0);
    check("ar_playing", int'(playing),       0);
    #3 n_rst = 1'b1;
    beats_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0);
      if (beat_pulse || playing) beats_seen++;
    end
    check("ar_idle", beats_seen, 0);
`else
    // ---------------- count-in: beats at k+1,k+5,k+9,k+13, downbeat k+17
    tempo = 22'd3;
    tick(1'b1, 1'b0);
    check("ci_b0_beat",     int'(beat_pulse),    1);
    check("ci_b0_count_in", int'(count_in),      1);
    check("ci_b0_measure",  int'(measure_pulse), 0);
    check("ci_b0_step",     int'(step),          0);
    check("ci_b0_playing",  int'(playing),       1);
    tick(1'b1, 1'b0);                    // play is ignored during count-in
    check("ci_play_ignored", int'(count_in), 1);
    wait_beat(n);
    check("ci_b1_spacing", n + 1, 4);
    check("ci_b1_count_in", int'(count_in), 1);
    for (int i = 2; i < 4; i++) begin
      wait_beat(n);
      check($sformatf("ci_b%0d_spacing", i), n, 4);
      check($sformatf("ci_b%0d_count_in", i), int'(count_in), 1);
      check($sformatf("ci_b%0d_measure", i), int'(measure_pulse), 0);
    end
    wait_beat(n);
    check("ci_down_spacing",  n, 4);
    check("ci_down_measure",  int'(measure_pulse), 1);
    check("ci_down_count_in", int'(count_in),      0);
    check("ci_down_step",     int'(step),          0);
    check("ci_down_playing",  int'(playing),       1);
    wait_beat(n);
    check("ci_next_step", int'(step), 1);

    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("ci_stop_count_in", int'(count_in),   0);
    check("ci_stop_playing",  int'(playing),    0);
    check("ci_stop_beat",     int'(beat_pulse), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
